uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link.sv | 199 +++++++++++++++++++
 tb/tb_uart_link.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link.sv
// uart_link: UART transmitter with a small TX FIFO plus a receiver with glitch rejection and error flags.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rx_i                           serial input (asynchronous, idle high)
//   tx_o                           serial output (idle high)
//   tx_data_i/tx_vld_i/tx_rdy_o    TX FIFO write handshake
//   tx_busy_o                      frame in flight or FIFO non-empty
//   rx_data_o/rx_vld_o/rx_rdy_i    received word handshake
//   rx_frame_err_o/rx_parity_err_o error flags, qualified by rx_vld_o
//   rx_overrun_o                   one-cycle pulse when a received word is dropped
module uart_link #(
    parameter int    CLK_FREQ_Hz   = 27000000,
    parameter int    BAUD_RATE     = 9600,
    parameter int    DATA_WIDTH    = 8,
    parameter string PARITY        = "NONE",
    parameter int    STOP_BITS     = 1,
    parameter int    TX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    output logic                  tx_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_vld_i,
    output logic                  tx_rdy_o,
    output logic                  tx_busy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_vld_o,
    input  logic                  rx_rdy_i,
    output logic                  rx_frame_err_o,
    output logic                  rx_parity_err_o,
    output logic                  rx_overrun_o
);
    localparam int DIV = (CLK_FREQ_Hz + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(TX_FIFO_DEPTH);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [3:0]    DW_END   = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    SB_END   = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    logic [DATA_WIDTH-1:0] mem_q [TX_FIFO_DEPTH];
    logic [AW-1:0]         wr_q, rd_q, rd_nxt;
    logic [AW:0]           cnt_q;
    state_t                tx_state_q;
    logic [CW-1:0]         tx_div_q;
    logic [3:0]            tx_bit_q;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_load_d;
    logic                  tx_par_q, tx_q, tx_bit_end, tx_pop, tx_more, wr;

    // The word being sent keeps its FIFO slot until its last stop bit ends,
    // so the FIFO count includes the frame in flight.
    assign rd_nxt     = rd_q + AW'(1);
    assign tx_bit_end = tx_div_q == DIV_END;
    assign tx_pop     = tx_state_q == STOP && tx_bit_end && tx_bit_q == SB_END;
    assign tx_rdy_o   = cnt_q != (AW + 1)'(TX_FIFO_DEPTH) || tx_pop;
    assign wr         = tx_vld_i && tx_rdy_o;
    assign tx_more    = cnt_q > (AW + 1)'(1) || wr;
    // A word written on the very cycle of the pop is forwarded so frames stay contiguous.
    assign tx_load_d  = (tx_state_q == IDLE) ? mem_q[rd_q] : (cnt_q == (AW + 1)'(1)) ? tx_data_i : mem_q[rd_nxt];
    assign tx_busy_o  = tx_state_q != IDLE || cnt_q != '0;
    assign tx_o       = tx_q;

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= tx_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            if (wr) wr_q <= wr_q + AW'(1);
            if (tx_pop) rd_q <= rd_nxt;
            cnt_q    <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(tx_pop);
            tx_div_q <= (tx_state_q == IDLE || tx_bit_end) ? '0 : tx_div_q + CW'(1);
            case (tx_state_q)
                IDLE: if (cnt_q != '0) begin
                    tx_state_q <= START;
                    tx_q       <= 1'b0;
                    tx_sh_q    <= tx_load_d;
                    tx_par_q   <= ^tx_load_d ^ PAR_ODD;
                end
                START: if (tx_bit_end) begin
                    tx_state_q <= DATA;
                    tx_q       <= tx_sh_q[0];
                    tx_sh_q    <= tx_sh_q >> 1;
                    tx_bit_q   <= '0;
                end
                DATA: if (tx_bit_end) begin
                    if (tx_bit_q == DW_END) begin
                        tx_state_q <= PAR_EN ? PAR : STOP;
                        tx_q       <= PAR_EN ? tx_par_q : 1'b1;
                        tx_bit_q   <= '0;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 4'd1;
                    end
                end
                PAR: if (tx_bit_end) begin
                    tx_state_q <= STOP;
                    tx_q       <= 1'b1;
                end
                STOP: if (tx_bit_end) begin
                    if (tx_bit_q != SB_END) begin
                        tx_bit_q <= tx_bit_q + 4'd1;
                    end else if (tx_more) begin
                        tx_state_q <= START;
                        tx_q       <= 1'b0;
                        tx_sh_q    <= tx_load_d;
                        tx_par_q   <= ^tx_load_d ^ PAR_ODD;
                    end else begin
                        tx_state_q <= IDLE;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    state_t                rx_state_q;
    logic                  s1_q, s2_q, prev_q;
    logic [CW-1:0]         rx_div_q;
    logic [3:0]            rx_bit_q;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_data_q;
    logic                  rx_pe_q, rx_fe_o_q, rx_pe_o_q, rx_vld_q, rx_ovr_q, rx_tick, rx_done;

    // The start bit is checked at its half-period; every later sample is a full period on.
    assign rx_tick = (rx_state_q == START) ? rx_div_q == HALF_END : rx_div_q == DIV_END;
    assign rx_done = rx_state_q == STOP && rx_tick;
    assign rx_data_o       = rx_data_q;
    assign rx_vld_o        = rx_vld_q;
    assign rx_frame_err_o  = rx_fe_o_q;
    assign rx_parity_err_o = rx_pe_o_q;
    assign rx_overrun_o    = rx_ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_pe_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_fe_o_q  <= 1'b0;
            rx_pe_o_q  <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            s1_q     <= rx_i;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            rx_div_q <= (rx_state_q == IDLE || rx_state_q == WAIT_HIGH || rx_tick) ? '0 : rx_div_q + CW'(1);
            case (rx_state_q)
                IDLE: if (prev_q && !s2_q) rx_state_q <= START;
                START: if (rx_tick) begin
                    rx_state_q <= s2_q ? IDLE : DATA;
                    rx_bit_q   <= '0;
                end
                DATA: if (rx_tick) begin
                    rx_sh_q <= {s2_q, rx_sh_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == DW_END) rx_state_q <= PAR_EN ? PAR : STOP;
                    else rx_bit_q <= rx_bit_q + 4'd1;
                end
                PAR: if (rx_tick) begin
                    rx_pe_q    <= s2_q ^ (^rx_sh_q) ^ PAR_ODD;
                    rx_state_q <= STOP;
                end
                STOP: if (rx_tick) rx_state_q <= s2_q ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (s2_q) rx_state_q <= IDLE;
                default: rx_state_q <= IDLE;
            endcase
            rx_ovr_q <= rx_done && rx_vld_q && !rx_rdy_i;
            if (rx_done && (!rx_vld_q || rx_rdy_i)) begin
                rx_data_q <= rx_sh_q;
                rx_fe_o_q <= !s2_q;
                rx_pe_o_q <= rx_pe_q;
                rx_vld_q  <= 1'b1;
            end else if (rx_rdy_i) begin
                rx_vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: directed self-checking bench for uart_link (DIV=16, 8E1 main instance, 8N1 receive-only instance).
module tb_uart_link;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       rx_drv = 1'b1, loop_en = 1'b0, rx_line;
    logic [7:0] tx_data = 8'h00;
    logic       tx_vld = 1'b0, rx_rdy = 1'b0;
    logic       tx_o, tx_rdy, tx_busy, rx_vld, rx_fe, rx_pe, rx_ovr;
    logic [7:0] rx_data;
    logic       np_rx = 1'b1, np_rdy = 1'b0, np_txv = 1'b0;
    logic [7:0] np_txd = 8'h00, np_data;
    logic       np_tx_o, np_tx_rdy, np_tx_busy, np_vld, np_fe, np_pe, np_ovr;
    int         checks = 0, errors = 0, ovr_cnt = 0;

    assign rx_line = loop_en ? tx_o : rx_drv;

    always #5 clk = ~clk;

    uart_link #(.CLK_FREQ_Hz(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY("EVEN"),
                .STOP_BITS(1), .TX_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_line), .tx_o(tx_o),
        .tx_data_i(tx_data), .tx_vld_i(tx_vld), .tx_rdy_o(tx_rdy), .tx_busy_o(tx_busy),
        .rx_data_o(rx_data), .rx_vld_o(rx_vld), .rx_rdy_i(rx_rdy),
        .rx_frame_err_o(rx_fe), .rx_parity_err_o(rx_pe), .rx_overrun_o(rx_ovr));

    uart_link #(.CLK_FREQ_Hz(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY("NONE"),
                .STOP_BITS(1), .TX_FIFO_DEPTH(4)) u_np (
        .clk(clk), .rst_n(rst_n), .rx_i(np_rx), .tx_o(np_tx_o),
        .tx_data_i(np_txd), .tx_vld_i(np_txv), .tx_rdy_o(np_tx_rdy), .tx_busy_o(np_tx_busy),
        .rx_data_o(np_data), .rx_vld_o(np_vld), .rx_rdy_i(np_rdy),
        .rx_frame_err_o(np_fe), .rx_parity_err_o(np_pe), .rx_overrun_o(np_ovr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rx_ovr) ovr_cnt++;
    endtask

    // Frame bit b of an 8E1 frame: start, 8 data LSB first, even parity, stop.
    function automatic logic exp_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (b == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic send_rx(input logic [7:0] w, input logic par, input logic stp);
        for (int b = 0; b < 11; b++) begin
            rx_drv = (b == 0) ? 1'b0 : (b <= 8) ? w[b-1] : (b == 9) ? par : stp;
            repeat (16) tick();
        end
        rx_drv = 1'b1;
    endtask

    task automatic accept();
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        chk("rx_vld_clears_after_accept", rx_vld, 0);
    endtask

    logic [7:0] ws [5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h96};
    int         exp_acc [5] = '{0, 1, 2, 3, 177};

    function automatic logic exp_stream(input int e);
        int p;
        if (e < 1) return 1'b1;
        p = e - 1;
        if (p / 176 >= 5) return 1'b1;
        return exp_bit(ws[p / 176], (p % 176) / 16);
    endfunction

    initial begin
        int acc [5];
        int idx, n, mn, nn, cnt_v, cnt_t;
        logic rdy_s, mfe, nfe, npe;
        logic [7:0] md, nd;
        logic [7:0] lw [3] = '{8'h00, 8'hFF, 8'h3C};
        logic [7:0] got_d [3];
        logic got_fe [3], got_pe [3];

        repeat (3) @(negedge clk);
        chk("rst_tx_o", tx_o, 1);
        chk("rst_tx_rdy", tx_rdy, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_fe", rx_fe, 0);
        chk("rst_rx_pe", rx_pe, 0);
        chk("rst_rx_ovr", rx_ovr, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        tx_data = 8'hA5;
        tx_vld  = 1'b1;
        @(posedge clk);
        #1 tx_vld = 1'b0;
        chk("a5_tx_high_on_write_cycle", tx_o, 1);
        chk("a5_busy_after_write", tx_busy, 1);
        @(posedge clk);
        for (int b = 0; b < 11; b++)
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                chk($sformatf("a5_bit%0d_clk%0d", b, c), tx_o, exp_bit(8'hA5, b));
            end
        @(negedge clk);
        chk("a5_idle_after_frame", tx_o, 1);
        chk("a5_not_busy_after_frame", tx_busy, 0);

        idx = 0;
        tx_data = ws[0];
        tx_vld  = 1'b1;
        for (int e = 0; e < 884; e++) begin
            rdy_s = tx_rdy;
            if (e == 4) chk("fifo_full_rdy_low", rdy_s, 0);
            if (e == 176) chk("fifo_full_rdy_still_low", rdy_s, 0);
            if (e == 177) chk("fifo_full_rdy_on_pop", rdy_s, 1);
            @(posedge clk);
            if (tx_vld && rdy_s) begin
                acc[idx] = e;
                idx++;
            end
            #1;
            if (idx < 5) tx_data = ws[idx];
            else tx_vld = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_cycle%0d", e), tx_o, exp_stream(e));
        end
        chk("b2b_words_accepted", idx, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("b2b_accept_cycle%0d", i), acc[i], exp_acc[i]);
        chk("b2b_not_busy_at_end", tx_busy, 0);

        loop_en = 1'b1;
        rx_rdy  = 1'b1;
        tx_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = lw[i];
            @(posedge clk);
            #1;
        end
        tx_vld = 1'b0;
        n = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (rx_vld) begin
                if (n < 3) begin
                    got_d[n]  = rx_data;
                    got_fe[n] = rx_fe;
                    got_pe[n] = rx_pe;
                end
                n++;
            end
        end
        chk("loop_word_count", n, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("loop_data%0d", i), got_d[i], lw[i]);
            chk($sformatf("loop_fe%0d", i), got_fe[i], 0);
            chk($sformatf("loop_pe%0d", i), got_pe[i], 0);
        end
        loop_en = 1'b0;
        rx_rdy  = 1'b0;
        repeat (4) tick();

        send_rx(8'h55, 1'b1, 1'b1);
        repeat (4) tick();
        chk("perr_vld", rx_vld, 1);
        chk("perr_data", rx_data, 8'h55);
        chk("perr_pe", rx_pe, 1);
        chk("perr_fe", rx_fe, 0);
        accept();

        send_rx(8'h3C, 1'b0, 1'b0);
        repeat (4) tick();
        chk("ferr_vld", rx_vld, 1);
        chk("ferr_data", rx_data, 8'h3C);
        chk("ferr_fe", rx_fe, 1);
        chk("ferr_pe", rx_pe, 0);
        accept();
        repeat (20) tick();

        rx_rdy = 1'b1;
        np_rdy = 1'b1;
        mn = 0;
        nn = 0;
        for (int i = 0; i < 360; i++) begin
            rx_drv = (i < 320) ? 1'b0 : 1'b1;
            np_rx  = (i < 160) ? 1'b0 : 1'b1;
            tick();
            if (rx_vld) begin
                mn++;
                md  = rx_data;
                mfe = rx_fe;
            end
            if (np_vld) begin
                nn++;
                nd  = np_data;
                nfe = np_fe;
                npe = np_pe;
            end
        end
        chk("brk_words", mn, 1);
        chk("brk_data", md, 8'h00);
        chk("brk_fe", mfe, 1);
        chk("brk10_words", nn, 1);
        chk("brk10_data", nd, 8'h00);
        chk("brk10_fe", nfe, 1);
        chk("brk10_pe_none", npe, 0);
        chk("np_tx_idle", np_tx_o, 1);
        chk("np_tx_rdy", np_tx_rdy, 1);
        chk("np_tx_busy", np_tx_busy, 0);
        chk("np_no_overrun", np_ovr, 0);

        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        cnt_v = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (rx_vld) cnt_v++;
        end
        chk("glitch_no_word", cnt_v, 0);
        rx_rdy = 1'b0;

        ovr_cnt = 0;
        send_rx(8'h12, ^8'h12, 1'b1);
        send_rx(8'h34, ^8'h34, 1'b1);
        repeat (8) tick();
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_vld_held", rx_vld, 1);
        chk("ovr_first_kept", rx_data, 8'h12);
        accept();

        tx_data = 8'h00;
        tx_vld  = 1'b1;
        @(posedge clk);
        #1 tx_vld = 1'b0;
        rx_drv = 1'b0;
        repeat (16) tick();
        rx_drv = 1'b1;
        repeat (16) tick();
        rx_drv = 1'b0;
        repeat (16) tick();
        chk("mid_tx_low_before_rst", tx_o, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_o", tx_o, 1);
        chk("mid_rst_tx_rdy", tx_rdy, 1);
        chk("mid_rst_tx_busy", tx_busy, 0);
        chk("mid_rst_rx_vld", rx_vld, 0);
        rx_drv = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        cnt_v = 0;
        cnt_t = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rx_vld) cnt_v++;
            if (!tx_o) cnt_t++;
        end
        chk("post_rst_no_rx_word", cnt_v, 0);
        chk("post_rst_tx_idle", cnt_t, 0);
        send_rx(8'hC3, ^8'hC3, 1'b1);
        repeat (4) tick();
        chk("post_rst_vld", rx_vld, 1);
        chk("post_rst_data", rx_data, 8'hC3);
        chk("post_rst_fe", rx_fe, 0);
        chk("post_rst_pe", rx_pe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
